// File: rtl/coh_avg_pkg.sv
// coh_avg_pkg: shared state encoding, default widths and accumulator width derivation
// for the coherent averager.
package coh_avg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DUMP,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_W            = 14;
    localparam int DEFAULT_SAMPLES_PER_FRAME = 64;
    localparam int DEFAULT_LOG2_N            = 4;

    // Summing 2**log2_n samples needs log2_n extra bits to never overflow.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/coh_avg_acc_ram.sv
// coh_avg_acc_ram: per-point accumulator storage, one synchronous write port and one
// combinational read port so a read-modify-write completes in a single cycle.
module coh_avg_acc_ram
    import coh_avg_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_SAMPLES_PER_FRAME,
    parameter int WIDTH  = acc_width(DEFAULT_DATA_W, DEFAULT_LOG2_N),
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the updated running sum at the end of the cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/coherent_average_core.sv
// coherent_average_core: accumulates 2**LOG2_N frames of SAMPLES_PER_FRAME samples
// point-by-point, then streams the averaged frame one word per cycle and flags done.
// Optional build macro COH_AVG_ROUND_EN: round half up with saturation instead of a
// plain floor shift when scaling the sums.
module coherent_average_core
    import coh_avg_pkg::*;
#(
    parameter int DATA_W            = DEFAULT_DATA_W,
    parameter int SAMPLES_PER_FRAME = DEFAULT_SAMPLES_PER_FRAME,
    parameter int LOG2_N            = DEFAULT_LOG2_N
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic signed [DATA_W-1:0]             data_in,
    input  logic                                 data_valid,
    output logic signed [DATA_W-1:0]             data_out,
    output logic                                 data_out_valid,
    output logic [$clog2(SAMPLES_PER_FRAME)-1:0] out_index,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_N);
    localparam int IDX_W = $clog2(SAMPLES_PER_FRAME);
    localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [LOG2_N-1:0] F_LAST = '1;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   k;
    logic [IDX_W-1:0]   next_k;
    logic [LOG2_N-1:0]  f;
    logic [LOG2_N-1:0]  next_f;
    logic               wr_en;
    logic               word_valid;
    logic [ACC_W-1:0]   wr_data;
    logic [ACC_W-1:0]   rd_data;
    logic [DATA_W-1:0]  scaled;

    // The same address k serves the accumulate read-modify-write and the dump read.
    coh_avg_acc_ram #(
        .DEPTH  (SAMPLES_PER_FRAME),
        .WIDTH  (ACC_W),
        .ADDR_W (IDX_W)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (k),
        .wr_data (wr_data),
        .rd_addr (k),
        .rd_data (rd_data)
    );

    // Frame 0 starts from zero, so stale sums from an aborted run never leak in.
    assign wr_data = ((f == '0) ? '0 : rd_data) + {{LOG2_N{data_in[DATA_W-1]}}, data_in};

`ifdef COH_AVG_ROUND_EN
    logic [DATA_W:0] rounded;

    // Adding half an LSB before the shift equals adding the top dropped bit afterwards;
    // only a positive result can overflow, which clamps to the largest positive word.
    always_comb begin
        rounded = {rd_data[ACC_W-1], rd_data[ACC_W-1 -: DATA_W]}
                + {{DATA_W{1'b0}}, rd_data[LOG2_N-1]};
        if (rounded[DATA_W] != rounded[DATA_W-1]) begin
            scaled = rounded[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            scaled = rounded[DATA_W-1:0];
        end
    end
`else
    // An arithmetic floor shift by LOG2_N is exactly the top DATA_W bits of the sum.
    assign scaled = rd_data[ACC_W-1 -: DATA_W];
`endif

    // Next-state, counter and write-enable logic; enable low always aborts to IDLE.
    always_comb begin
        next_state = state;
        next_k     = k;
        next_f     = f;
        wr_en      = 1'b0;
        word_valid = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = ACCUM;
                    next_k     = '0;
                    next_f     = '0;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    next_state = IDLE;
                    next_k     = '0;
                    next_f     = '0;
                end else if (data_valid) begin
                    wr_en = 1'b1;
                    if (k == K_LAST) begin
                        next_k = '0;
                        next_f = f + 1'b1;
                        if (f == F_LAST) begin
                            next_state = DUMP;
                        end
                    end else begin
                        next_k = k + 1'b1;
                    end
                end
            end
            DUMP: begin
                if (!enable) begin
                    next_state = IDLE;
                    next_k     = '0;
                    next_f     = '0;
                end else begin
                    word_valid = 1'b1;
                    if (k == K_LAST) begin
                        next_k     = '0;
                        next_state = DONE;
                    end else begin
                        next_k = k + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs read zero whenever no word is issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            k              <= '0;
            f              <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            out_index      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= next_state;
            k              <= next_k;
            f              <= next_f;
            data_out       <= word_valid ? scaled : '0;
            data_out_valid <= word_valid;
            out_index      <= word_valid ? k : '0;
            busy           <= (state == ACCUM) || (state == DUMP);
            done           <= (state == DONE);
        end
    end

endmodule
